// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder and its byte-lane storage.
// Lane 0 of a word_t is the byte at the lowest address.
package mem_pkg;

    typedef logic [7:0]   byte_t;
    typedef byte_t [0:3]  word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    // Word index of a byte address; bits above the array depth are dropped so addresses alias.
    function automatic logic [31:0] word_index(input logic [31:0] addr, input int width);
        return (addr >> 2) & ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake between the core's data port and the memory responder.
// The core side is the master, the memory side the slave.
interface data_mem_responder_if;
    import mem_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    word_t       req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    word_t       resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_addr, req_write, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );

endinterface

// File: rtl/data_mem_responder_byte_lane_ram.sv
// One 8-bit lane of data memory: single-port synchronous array with write enable
// and a registered read port that holds its value while i_re is low.
module byte_lane_ram
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_we,
    input  logic                  i_re,
    input  byte_t                 i_wdata,
    output byte_t                 o_rdata
);

    byte_t r_mem [2**ADDR_WIDTH];
    byte_t r_rdata;

    // NOTE: the array has no reset branch on purpose; contents survive reset and it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder: one request at a time, committed LATENCY
// cycles after acceptance and returned over a valid/ready response handshake.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 4
) (
    input  logic               clk,
    input  logic               rst_b,
    data_mem_responder_if.slave bus
);

    localparam int          CNT_W    = $clog2(LATENCY) + 1;
    localparam int unsigned CNT_LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;

    resp_state_t      r_state;
    resp_state_t      w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic [31:0]      r_addr;
    logic             r_write;
    word_t            r_wdata;
    logic             r_err;

    logic                  w_accept;
    logic                  w_commit;
    logic [31:0]           w_addr;
    logic                  w_write;
    word_t                 w_wdata;
    logic                  w_misaligned;
    logic [ADDR_WIDTH-1:0] w_index;
    logic                  w_we;
    logic                  w_re;
    word_t                 w_ram_rdata;

    assign w_accept = (r_state == IDLE) && bus.req_valid;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_commit     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 1) begin
                        w_next_state = RESP;
                        w_commit     = 1'b1;
                    end else begin
                        w_next_state = BUSY;
                        w_next_cnt   = CNT_W'(CNT_LOAD);
                    end
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_next_state = RESP;
                    w_commit     = 1'b1;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // With LATENCY = 1 the commit edge is the accept edge, so the live request is used.
    assign w_addr       = (r_state == IDLE) ? bus.req_addr  : r_addr;
    assign w_write      = (r_state == IDLE) ? bus.req_write : r_write;
    assign w_wdata      = (r_state == IDLE) ? bus.req_wdata : r_wdata;
    assign w_misaligned = (w_addr[1:0] != 2'b00);
    assign w_index      = ADDR_WIDTH'(word_index(w_addr, ADDR_WIDTH));

    // Reset on the commit edge must suppress the write as well as the state change.
    assign w_we = w_commit && !rst_b && !w_misaligned &&  w_write;
    assign w_re = w_commit && !rst_b && !w_misaligned && !w_write;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        byte_lane_ram #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_lane (
            .clk     (clk),
            .i_addr  (w_index),
            .i_we    (w_we),
            .i_re    (w_re),
            .i_wdata (w_wdata[g]),
            .o_rdata (w_ram_rdata[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_addr  <= bus.req_addr;
                r_write <= bus.req_write;
                r_wdata <= bus.req_wdata;
            end
            if (w_commit) begin
                r_err <= w_misaligned;
            end else if ((r_state == RESP) && bus.resp_ready) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_error = (r_state == RESP) && r_err;
    assign bus.resp_rdata = ((r_state == RESP) && !r_err) ? (r_write ? r_wdata : w_ram_rdata) : '0;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's data-memory port: accepts one word read or write request at a time, serves it after a fixed, parameterised latency, and returns the result through a valid/ready response handshake. Storage is byte-lane organised (four 8-bit lanes per word), matching the core's byte-array data buses. The block is the multi-cycle memory model the stalling core and the upcoming cache are built and verified against.

## Interface
- ADDR_WIDTH, 12: word-index bits; capacity is 2^ADDR_WIDTH words.
- LATENCY, 4: cycles from request accept to first response-valid cycle; legal range is LATENCY ≥ 1.

- clk  in  1  rising-edge clock.
- rst_b  in  1  reset, synchronous and active-high: 1 = reset, sampled on the rising edge of clk.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address.
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  8×[0:3]  write data; lane i is the byte at address addr+i.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  8×[0:3]  word at the addressed location after the operation completes; lane order as req_wdata.
- resp_error  out  1  request was misaligned and no access was performed.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE
  - req_ready = 1.
  - On req_valid, latch addr, write and wdata.
  - If LATENCY = 1, go to RESP.
  - Otherwise load cnt = LATENCY−2 and go to BUSY.
- BUSY
  - req_ready = 0.
  - When cnt = 0, go to RESP; otherwise decrement cnt.
- Transition into RESP (the commit edge)
  - Word index = addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias modulo capacity.
  - If addr[1:0] ≠ 0: resp_error = 1, resp_rdata = 0, no write.
  - Else, write: all four lanes are written, and resp_rdata = wdata.
  - Else, read: resp_rdata = the stored word.
- RESP
  - resp_valid = 1.
  - resp_rdata and resp_error are held stable until resp_valid && resp_ready.
  - On that handshake, go to IDLE, clear resp_valid, clear resp_error and zero resp_rdata.
- A request is never accepted in BUSY or RESP; req_valid is ignored there.
- The storage array has no reset; contents persist across reset.

## Timing
- Request accepted at edge t (req_valid && req_ready).
- resp_valid is first high in the cycle after edge t+LATENCY−1, i.e. LATENCY cycles after acceptance.
- Write commit occurs on the same edge that raises resp_valid.
- Response consumed at edge r: req_ready is 1 in the following cycle. Minimum request-to-request spacing is LATENCY+1 cycles.
- A read accepted after a write's response handshake returns the written data.
- Reset values: state = IDLE, req_ready = 1 in the first cycle after reset, resp_valid = 0, resp_error = 0, resp_rdata = 0, cnt = 0.
- Reset during BUSY aborts the request. A pending write is not committed unless its commit edge has already passed.
- Reset during RESP drops the response.
- Reset and req_valid on the same edge: reset wins and the request is not accepted.

## Structure
- Shared package mem_pkg:
  - byte_t (8 bits).
  - word_t (byte_t[0:3]).
  - resp_state_t enum {IDLE, BUSY, RESP}.
  - Function word_index(addr, width).
- Sub-module byte_lane_ram: a 2^ADDR_WIDTH × 8 single-port synchronous array with per-lane write enable and registered read. It is instantiated four times, once per lane, so the cache can later reuse it per lane.
- cnt width is $clog2(LATENCY)+1.

## Test plan
- Basic write/read, LATENCY = 4:
  - Write 0x100, data {0xDE,0xAD,0xBE,0xEF}. resp_valid is high exactly 4 cycles after accept, resp_error = 0.
  - Then read 0x100. resp_rdata = {0xDE,0xAD,0xBE,0xEF}.
- Misaligned write: write 0x102, data {1,2,3,4} → resp_error = 1, resp_rdata = 0. A subsequent read of 0x100 still returns {0xDE,0xAD,0xBE,0xEF}.
- Backpressure: hold resp_ready = 0 for 10 cycles after resp_valid.
  - resp_valid and resp_rdata stay stable throughout, and req_ready = 0.
  - Raise resp_ready: req_ready = 1 next cycle.
- Aliasing, ADDR_WIDTH = 12:
  - Write 0x4000_0010 with {0x11,0x22,0x33,0x44}.
  - Read 0x0000_0010 → {0x11,0x22,0x33,0x44}.
- Reset mid-BUSY:
  - Write 0x200 = {0xAA,…}, then assert rst_b 2 cycles after accept. resp_valid stays 0.
  - Read 0x200 returns the prior contents, not 0xAA….
- LATENCY = 1 back-to-back with resp_ready tied high:
  - Requests are accepted every 2 cycles.
  - Each resp_valid arrives 1 cycle after its accept.
